// File: rtl/mult_pkg.sv
// Shared definitions for the sequential arithmetic blocks:
// FSM state encoding and counter sizing.
package mult_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_RUN   = 2'd1;
  localparam logic [1:0] ENC_FIXUP = 2'd2;
  localparam logic [1:0] ENC_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    RUN   = ENC_RUN,
    FIXUP = ENC_FIXUP,
    DONE  = ENC_DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Iteration tick generator: one tick every DIV enabled clocks.
// Cleared synchronously so the first tick lands DIV clocks later.
module tick_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LP_LAST = DW'(DIV - 1);

  logic [DW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LP_LAST);
  assign tick   = en && w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (sync_clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier with start/busy/done handshake,
// optional signed operation and synchronous abort.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int SIGNED_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      signed_mode,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          data_a,
  input  logic [WIDTH-1:0]          data_b,
  output logic                      busy,
  output logic                      done,
  output logic [2*WIDTH-1:0]        product,
  output logic [cnt_w(WIDTH)-1:0]   iter_cnt
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LP_ITERS = CW'(WIDTH);

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mult;
  logic [PW-1:0]    r_product;
  logic [CW-1:0]    r_iter;
  logic             r_neg;

  logic             w_accept;
  logic             w_sgn;
  logic             w_en;
  logic             w_tick;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_accept = (r_state == IDLE) && start && !clear;
  assign w_sgn    = signed_mode && (SIGNED_EN != 0);
  assign w_a_neg  = w_sgn && data_a[WIDTH-1];
  assign w_b_neg  = w_sgn && data_b[WIDTH-1];
  // Magnitudes fit in WIDTH bits unsigned, so -2^(WIDTH-1) is exact.
  assign w_a_mag  = w_a_neg ? (~data_a + WIDTH'(1)) : data_a;
  assign w_b_mag  = w_b_neg ? (~data_b + WIDTH'(1)) : data_b;
  assign w_en     = (r_state == RUN) && (r_iter != LP_ITERS);

  tick_divider #(
    .DIV(DIV)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (w_en),
    .sync_clr(w_accept | clear),
    .tick    (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (start) w_next = RUN;
        RUN:     if (r_iter == LP_ITERS) w_next = FIXUP;
        FIXUP:   w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mult    <= '0;
      r_product <= '0;
      r_iter    <= '0;
      r_neg     <= 1'b0;
    end else if (clear) begin
      r_iter    <= '0;
    end else if (w_accept) begin
      r_acc     <= '0;
      r_mcand   <= PW'(w_a_mag);
      r_mult    <= w_b_mag;
      r_iter    <= '0;
      r_neg     <= w_a_neg ^ w_b_neg;
    end else if (w_tick) begin
      if (r_mult[0]) r_acc <= r_acc + r_mcand;
      r_mcand   <= r_mcand << 1;
      r_mult    <= r_mult >> 1;
      r_iter    <= r_iter + CW'(1);
    end else if (r_state == FIXUP) begin
      r_product <= r_neg ? (~r_acc + PW'(1)) : r_acc;
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign product  = r_product;
  assign iter_cnt = r_iter;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: three parameter
// sets share one stimulus bus; each check targets one instance.
module tb_seq_shift_add_mult;

  logic clk;
  logic rst_n;
  logic r_start;
  logic r_sm;
  logic r_clr;
  logic [7:0] r_a;
  logic [7:0] r_b;

  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [15:0] prod_v [3];
  logic [3:0]  it_v [3];

  int checks;
  int failures;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  seq_shift_add_mult #(.WIDTH(8), .DIV(1), .SIGNED_EN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(r_start),
    .signed_mode(r_sm), .clear(r_clr),
    .data_a(r_a), .data_b(r_b),
    .busy(busy_v[0]), .done(done_v[0]),
    .product(prod_v[0]), .iter_cnt(it_v[0])
  );

  seq_shift_add_mult #(.WIDTH(8), .DIV(1), .SIGNED_EN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(r_start),
    .signed_mode(r_sm), .clear(r_clr),
    .data_a(r_a), .data_b(r_b),
    .busy(busy_v[1]), .done(done_v[1]),
    .product(prod_v[1]), .iter_cnt(it_v[1])
  );

  seq_shift_add_mult #(.WIDTH(8), .DIV(4), .SIGNED_EN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(r_start),
    .signed_mode(r_sm), .clear(r_clr),
    .data_a(r_a), .data_b(r_b),
    .busy(busy_v[2]), .done(done_v[2]),
    .product(prod_v[2]), .iter_cnt(it_v[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_mul(
    input logic [7:0] a, input logic [7:0] b, input logic sgn);
    int x;
    int y;
    if (sgn) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    return 16'(x * y);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_v != 3'b000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_v != 3'b000) chk("idle_timeout", 32'(busy_v), 0);
  endtask

  task automatic do_op(input int s,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic sm,
                       input logic hold,
                       output int cyc);
    wait_idle();
    r_a = a;
    r_b = b;
    r_sm = sm;
    r_start = 1'b1;
    @(negedge clk);
    if (!hold) begin
      r_start = 1'b0;
      r_a = 8'($urandom);
      r_b = 8'($urandom);
      r_sm = 1'($urandom);
    end
    cyc = 0;
    while (!done_v[s] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!done_v[s]) chk("done_timeout", 32'(done_v[s]), 1);
  endtask

  initial begin
    int cyc;
    int n;
    int seen;
    int s;
    logic [7:0] a;
    logic [7:0] b;
    logic sm;
    checks = 0;
    failures = 0;

    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    tbl[3] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tbl[4] = '{8'h00, 8'hC8, 1'b0, 16'h0000};
    tbl[5] = '{8'h80, 8'h02, 1'b0, 16'h0100};
    tbl[6] = '{8'hFE, 8'h03, 1'b1, 16'hFFFA};
    tbl[7] = '{8'h07, 8'hF9, 1'b1, 16'hFFCF};

    rst_n = 1'b0;
    r_start = 1'b0;
    r_sm = 1'b0;
    r_clr = 1'b0;
    r_a = 8'h00;
    r_b = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_v), 0);
    chk("rst_done", 32'(done_v), 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_prod%0d", i), 32'(prod_v[i]), 0);
      chk($sformatf("rst_iter%0d", i), 32'(it_v[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_op(0, tbl[i].a, tbl[i].b, tbl[i].sm, 1'b0, cyc);
      chk($sformatf("tbl%0d_prod", i), 32'(prod_v[0]), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_lat", i), cyc, 10);
      @(negedge clk);
      chk($sformatf("tbl%0d_pulse", i), 32'(done_v[0]), 0);
      chk($sformatf("tbl%0d_idle", i), 32'(busy_v[0]), 0);
    end

    do_op(1, 8'h80, 8'h02, 1'b1, 1'b0, cyc);
    chk("nosgn_prod", 32'(prod_v[1]), 32'h0100);
    chk("sgn_prod", 32'(prod_v[0]), 32'hFF00);

    for (int i = 0; i < 24; i++) begin
      s = i % 2;
      a = 8'($urandom);
      b = 8'($urandom);
      sm = 1'($urandom);
      do_op(s, a, b, sm, 1'b0, cyc);
      chk($sformatf("rnd%0d_prod a=%0h b=%0h sm=%0d", i, a, b, sm),
          32'(prod_v[s]), 32'(ref_mul(a, b, sm && (s == 0))));
      chk($sformatf("rnd%0d_lat", i), cyc, 10);
    end

    wait_idle();
    r_a = 8'd3;
    r_b = 8'd5;
    r_sm = 1'b0;
    r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    n = 0;
    while (!done_v[2] && n < 60) begin
      if (n <= 32) chk($sformatf("div4_iter_n%0d", n), 32'(it_v[2]), n / 4);
      if (n == 5) begin
        r_start = 1'b1;
        r_a = 8'hAA;
        r_b = 8'h55;
      end
      if (n == 6) r_start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("div4_lat", n, 34);
    chk("div4_prod", 32'(prod_v[2]), 15);
    @(negedge clk);
    chk("div4_pulse", 32'(done_v[2]), 0);

    wait_idle();
    r_a = 8'd9;
    r_b = 8'd9;
    r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    n = 0;
    while (it_v[2] != 4'd3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("clr_reach3", 32'(it_v[2]), 3);
    r_clr = 1'b1;
    @(negedge clk);
    r_clr = 1'b0;
    chk("clr_busy", 32'(busy_v[2]), 0);
    chk("clr_done", 32'(done_v[2]), 0);
    chk("clr_iter", 32'(it_v[2]), 0);
    chk("clr_prod", 32'(prod_v[2]), 32'h000F);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_v[2]) seen++;
    end
    chk("clr_no_done", seen, 0);
    do_op(2, 8'd7, 8'd6, 1'b0, 1'b0, cyc);
    chk("clr_next_prod", 32'(prod_v[2]), 42);
    chk("clr_next_lat", cyc, 34);

    wait_idle();
    r_start = 1'b1;
    r_clr = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    r_clr = 1'b0;
    chk("start_clr_idle", 32'(busy_v), 0);

    do_op(0, 8'd12, 8'd11, 1'b0, 1'b1, cyc);
    chk("b2b_prod1", 32'(prod_v[0]), 132);
    chk("b2b_lat1", cyc, 10);
    @(negedge clk);
    chk("b2b_gap", 32'(busy_v[0]), 0);
    @(negedge clk);
    r_start = 1'b0;
    chk("b2b_reaccept", 32'(busy_v[0]), 1);
    chk("b2b_iter0", 32'(it_v[0]), 0);
    n = 0;
    while (!done_v[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat2", n, 10);
    chk("b2b_prod2", 32'(prod_v[0]), 132);

    wait_idle();
    r_a = 8'hFF;
    r_b = 8'h10;
    r_sm = 1'b0;
    r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy_v), 0);
    chk("mrst_done", 32'(done_v), 0);
    chk("mrst_prod0", 32'(prod_v[0]), 0);
    chk("mrst_iter0", 32'(it_v[0]), 0);
    chk("mrst_prod2", 32'(prod_v[2]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(0, 8'd0, 8'd200, 1'b0, 1'b0, cyc);
    chk("zero_prod", 32'(prod_v[0]), 0);
    chk("zero_lat", cyc, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
